// File: rtl/response_router.sv
// Read-response router: keeps an in-order FIFO of slave selects and steers the
// head slave's read channel (or an internal decode-error beat) to the master.
module response_router #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_push,
    input  logic [2:0]               a_sel,
    output logic                     a_full,
    input  logic [DATA_W-1:0]        s_rdata0,
    input  logic [DATA_W-1:0]        s_rdata1,
    input  logic [DATA_W-1:0]        s_rdata2,
    input  logic [DATA_W-1:0]        s_rdata3,
    input  logic [DATA_W-1:0]        s_rdata4,
    input  logic [1:0]               s_rresp0,
    input  logic [1:0]               s_rresp1,
    input  logic [1:0]               s_rresp2,
    input  logic [1:0]               s_rresp3,
    input  logic [1:0]               s_rresp4,
    input  logic                     s_rlast0,
    input  logic                     s_rlast1,
    input  logic                     s_rlast2,
    input  logic                     s_rlast3,
    input  logic                     s_rlast4,
    input  logic                     s_rvalid0,
    input  logic                     s_rvalid1,
    input  logic                     s_rvalid2,
    input  logic                     s_rvalid3,
    input  logic                     s_rvalid4,
    output logic                     s_rready0,
    output logic                     s_rready1,
    output logic                     s_rready2,
    output logic                     s_rready3,
    output logic                     s_rready4,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [1:0]               m_rresp,
    output logic                     m_rlast,
    output logic                     m_rvalid,
    input  logic                     m_rready,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [7:0]               beat_cnt,
    output logic                     ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [2:0]       NUM_SLV  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUTE = 2'b01,
        ST_ERR   = 2'b10
    } state_t;

    // Selects 5-7 have no slave behind them and are answered internally.
    function automatic state_t sel_state(input logic [2:0] sel);
        if (sel < NUM_SLV) begin
            return ST_ROUTE;
        end else begin
            return ST_ERR;
        end
    endfunction

    logic [DATA_W-1:0] w_s_rdata [5];
    logic [1:0]        w_s_rresp [5];
    logic [4:0]        w_s_rlast;
    logic [4:0]        w_s_rvalid;
    logic [4:0]        w_s_rready;

    logic [2:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_beat;
    logic              r_ovf;
    state_t            r_state;
    logic [2:0]        r_head_sel;

    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_sel_nxt;
    state_t            w_state_nxt;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_beat;
    logic [DATA_W-1:0] w_m_rdata;
    logic [1:0]        w_m_rresp;
    logic              w_m_rlast;
    logic              w_m_rvalid;

    assign w_s_rdata[0] = s_rdata0;
    assign w_s_rdata[1] = s_rdata1;
    assign w_s_rdata[2] = s_rdata2;
    assign w_s_rdata[3] = s_rdata3;
    assign w_s_rdata[4] = s_rdata4;
    assign w_s_rresp[0] = s_rresp0;
    assign w_s_rresp[1] = s_rresp1;
    assign w_s_rresp[2] = s_rresp2;
    assign w_s_rresp[3] = s_rresp3;
    assign w_s_rresp[4] = s_rresp4;
    assign w_s_rlast    = {s_rlast4, s_rlast3, s_rlast2, s_rlast1, s_rlast0};
    assign w_s_rvalid   = {s_rvalid4, s_rvalid3, s_rvalid2, s_rvalid1, s_rvalid0};

    assign w_full = (r_cnt == FULL_CNT);
    assign w_push = a_push & ~w_full;
    assign w_beat = w_m_rvalid & m_rready;
    assign w_pop  = w_beat & w_m_rlast;

    // Pointer and occupancy update for the select FIFO.
    always_comb begin
        w_wr_nxt  = r_wr;
        w_rd_nxt  = r_rd;
        w_cnt_nxt = r_cnt;
        if (w_push) begin
            w_wr_nxt = r_wr + PTR_W'(1);
        end else begin
            w_wr_nxt = r_wr;
        end
        if (w_pop) begin
            w_rd_nxt = r_rd + PTR_W'(1);
        end else begin
            w_rd_nxt = r_rd;
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Next head select; the slot at the new read pointer may be written this very cycle.
    always_comb begin
        w_sel_nxt = 3'd0;
        if (w_push && (r_wr == w_rd_nxt)) begin
            w_sel_nxt = a_sel;
        end else begin
            w_sel_nxt = r_mem[w_rd_nxt];
        end
    end

    // FIFO storage, pointers, occupancy, beat counter and overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 3'd0;
            end
            r_wr   <= {PTR_W{1'b0}};
            r_rd   <= {PTR_W{1'b0}};
            r_cnt  <= ZERO_CNT;
            r_beat <= 8'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= a_sel;
            end
            r_wr  <= w_wr_nxt;
            r_rd  <= w_rd_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_pop) begin
                r_beat <= 8'd0;
            end else if (w_beat && (r_beat != 8'hFF)) begin
                r_beat <= r_beat + 8'd1;
            end else begin
                r_beat <= r_beat;
            end
            if (a_push && w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // State register, with the head select captured alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_head_sel <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_head_sel <= w_sel_nxt;
        end
    end

    // Next-state decode from the post-update occupancy and head select.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_cnt_nxt == ZERO_CNT) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = sel_state(w_sel_nxt);
        end
    end

    // Output steering: zero-latency pass-through of the head slave or the error beat.
    always_comb begin
        w_m_rvalid = 1'b0;
        w_m_rdata  = {DATA_W{1'b0}};
        w_m_rresp  = 2'b00;
        w_m_rlast  = 1'b0;
        w_s_rready = 5'b00000;
        case (r_state)
            ST_IDLE: begin
                w_m_rvalid = 1'b0;
            end
            ST_ROUTE: begin
                if (r_head_sel < NUM_SLV) begin
                    w_m_rvalid             = w_s_rvalid[r_head_sel];
                    w_m_rdata              = w_s_rdata[r_head_sel];
                    w_m_rresp              = w_s_rresp[r_head_sel];
                    w_m_rlast              = w_s_rlast[r_head_sel];
                    w_s_rready[r_head_sel] = m_rready;
                end else begin
                    w_m_rvalid = 1'b0;
                end
            end
            ST_ERR: begin
                w_m_rvalid = 1'b1;
                w_m_rdata  = {DATA_W{1'b0}};
                w_m_rresp  = 2'b11;
                w_m_rlast  = 1'b1;
            end
            default: begin
                w_m_rvalid = 1'b0;
            end
        endcase
    end

    assign m_rvalid    = w_m_rvalid;
    assign m_rdata     = w_m_rdata;
    assign m_rresp     = w_m_rresp;
    assign m_rlast     = w_m_rlast;
    assign s_rready0   = w_s_rready[0];
    assign s_rready1   = w_s_rready[1];
    assign s_rready2   = w_s_rready[2];
    assign s_rready3   = w_s_rready[3];
    assign s_rready4   = w_s_rready[4];
    assign a_full      = w_full;
    assign outstanding = r_cnt;
    assign beat_cnt    = r_beat;
    assign ovf_err     = r_ovf;

endmodule

// File: tb/tb_response_router.sv
// Randomized and directed bench for response_router, checked against a
// queue-based model of in-order response return.
module tb_response_router;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_push;
    logic [2:0]        a_sel;
    logic              a_full;
    logic [DATA_W-1:0] sd [5];
    logic [1:0]        sr [5];
    logic              sl [5];
    logic              sv [5];
    logic [4:0]        rdy;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic [2:0]        outstanding;
    logic [7:0]        beat_cnt;
    logic              ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    int q[$];
    int m_beats = 0;
    bit m_ovf = 0;
    bit e_valid;
    bit e_last;

    always #5 clk = ~clk;

    response_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .a_push(a_push), .a_sel(a_sel), .a_full(a_full),
        .s_rdata0(sd[0]), .s_rdata1(sd[1]), .s_rdata2(sd[2]), .s_rdata3(sd[3]), .s_rdata4(sd[4]),
        .s_rresp0(sr[0]), .s_rresp1(sr[1]), .s_rresp2(sr[2]), .s_rresp3(sr[3]), .s_rresp4(sr[4]),
        .s_rlast0(sl[0]), .s_rlast1(sl[1]), .s_rlast2(sl[2]), .s_rlast3(sl[3]), .s_rlast4(sl[4]),
        .s_rvalid0(sv[0]), .s_rvalid1(sv[1]), .s_rvalid2(sv[2]), .s_rvalid3(sv[3]), .s_rvalid4(sv[4]),
        .s_rready0(rdy[0]), .s_rready1(rdy[1]), .s_rready2(rdy[2]), .s_rready3(rdy[3]), .s_rready4(rdy[4]),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .outstanding(outstanding), .beat_cnt(beat_cnt), .ovf_err(ovf_err)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_push   = 1'b0;
        a_sel    = 3'd0;
        m_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sd[i] = 32'd0;
            sr[i] = 2'd0;
            sl[i] = 1'b0;
            sv[i] = 1'b0;
        end
    endtask

    // Compare against the model on the falling edge, then advance the model on the rising edge.
    task automatic tick();
        logic [DATA_W-1:0] e_data;
        logic [1:0]        e_resp;
        logic [4:0]        e_rdy;
        int                sz;
        bit                pop;
        @(negedge clk);
        e_valid = 0; e_last = 0; e_data = 32'd0; e_resp = 2'd0; e_rdy = 5'd0;
        if (q.size() > 0) begin
            if (q[0] < 5) begin
                e_valid = sv[q[0]];
                e_data  = sd[q[0]];
                e_resp  = sr[q[0]];
                e_last  = sl[q[0]];
                e_rdy[q[0]] = m_rready;
            end else begin
                e_valid = 1; e_last = 1; e_resp = 2'b11; e_data = 32'd0;
            end
        end
        chk_eq("m_rvalid", m_rvalid, e_valid);
        if (e_valid) begin
            chk_eq("m_rdata", m_rdata, e_data);
            chk_eq("m_rresp", m_rresp, e_resp);
            chk_eq("m_rlast", m_rlast, e_last);
        end
        chk_eq("s_rready", rdy, e_rdy);
        chk_eq("outstanding", outstanding, q.size());
        chk_eq("a_full", a_full, q.size() == DEPTH);
        chk_eq("beat_cnt", beat_cnt, m_beats);
        chk_eq("ovf_err", ovf_err, m_ovf);
        @(posedge clk);
        pop = e_valid && m_rready && e_last;
        sz  = q.size();
        if (e_valid && m_rready) begin
            if (pop) m_beats = 0;
            else if (m_beats < 255) m_beats++;
        end
        if (pop) void'(q.pop_front());
        if (a_push) begin
            if (sz < DEPTH) q.push_back(int'(a_sel));
            else m_ovf = 1;
        end
        #1;
    endtask

    task automatic push_one(input logic [2:0] sel);
        a_push = 1'b1;
        a_sel  = sel;
        tick();
        a_push = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        sv[2] = 1'b1;
        m_rready = 1'b1;
        #3;
        chk_eq("rst_m_rvalid", m_rvalid, 1'b0);
        chk_eq("rst_s_rready", rdy, 5'd0);
        chk_eq("rst_outstanding", outstanding, 3'd0);
        chk_eq("rst_a_full", a_full, 1'b0);
        chk_eq("rst_beat_cnt", beat_cnt, 8'd0);
        chk_eq("rst_ovf_err", ovf_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        tick();

        // Eight-beat burst from slave 1 while other slaves also assert valid.
        push_one(3'd1);
        for (int b = 0; b < 8; b++) begin
            m_rready = 1'b1;
            sv[1] = 1'b1; sl[1] = (b == 7); sd[1] = 32'h1000 + b; sr[1] = 2'(b);
            sv[0] = 1'b1; sv[3] = 1'b1;
            tick();
        end
        idle_inputs();
        tick();

        // Slave 3 waits for slave 2's burst to complete.
        push_one(3'd2);
        push_one(3'd3);
        sv[3] = 1'b1; sd[3] = 32'h3333_0000; sl[3] = 1'b1; m_rready = 1'b1;
        tick(); tick();
        sv[2] = 1'b1; sd[2] = 32'h2222_0000;
        tick();
        sl[2] = 1'b1; sd[2] = 32'h2222_0001;
        tick();
        tick();
        idle_inputs();
        tick();

        // Decode-error responder holds its beat until the master is ready.
        push_one(3'd6);
        tick();
        m_rready = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Long burst to exercise beat_cnt saturation.
        push_one(3'd0);
        sv[0] = 1'b1; m_rready = 1'b1;
        for (int b = 0; b < 260; b++) begin
            sd[0] = $urandom;
            tick();
        end
        sl[0] = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            a_push   = ($urandom_range(0, 2) == 0);
            a_sel    = 3'($urandom_range(0, 7));
            m_rready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 5; i++) begin
                sv[i] = 1'($urandom_range(0, 1));
                sl[i] = ($urandom_range(0, 3) == 0);
                sd[i] = $urandom;
                sr[i] = 2'($urandom_range(0, 3));
            end
            tick();
        end

        // Drain, then fill to full and overflow.
        idle_inputs();
        m_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sv[i] = 1'b1; sl[i] = 1'b1;
        end
        for (int c = 0; c < 10; c++) tick();
        idle_inputs();
        push_one(3'd7);
        push_one(3'd1);
        push_one(3'd5);
        push_one(3'd4);
        push_one(3'd2);
        tick();

        // Pop while full with a push in the same cycle: push is dropped, next one lands.
        m_rready = 1'b1;
        a_push = 1'b1; a_sel = 3'd0;
        tick();
        m_rready = 1'b0;
        a_sel = 3'd3;
        tick();
        a_push = 1'b0;
        tick();

        // Clear the queue, then start a slave-4 burst and reset in the middle of it.
        m_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sv[i] = 1'b1; sl[i] = 1'b1;
        end
        for (int c = 0; c < 8; c++) tick();
        idle_inputs();
        push_one(3'd4);
        sv[4] = 1'b1; m_rready = 1'b1; sd[4] = 32'h4444_4444;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_eq("rst_mid_outstanding", outstanding, 3'd0);
        chk_eq("rst_mid_m_rvalid", m_rvalid, 1'b0);
        chk_eq("rst_mid_s_rready4", rdy[4], 1'b0);
        chk_eq("rst_mid_ovf_err", ovf_err, 1'b0);
        q.delete();
        m_beats = 0;
        m_ovf = 0;
        tick();
        reset = 1'b1;
        sl[4] = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
